// File: rtl/uart_tx.sv
// UART transmitter: serialises one DATA_WIDTH-bit word per accepted request as
// start, data (LSB first), optional parity and one stop bit, Prescale clocks per bit.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_q,  state_d;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic [5:0]            cnt_q,    cnt_d;
    logic [CW-1:0]         bit_q,    bit_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q,    par_d;
    logic [5:0]            presc_q,  presc_d;

    logic                  last_s;
    logic [5:0]            reload_s;

    // Prescale of 0 wraps the reload to 63, giving a 64-cycle bit.
    assign last_s   = (cnt_q == 6'd0);
    assign reload_s = presc_q - 6'd1;

    // Next-state and datapath computation for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid && !busy_q) begin
                    shift_d  = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                    presc_d  = Prescale;
                    cnt_d    = Prescale - 6'd1;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end else begin
                    cnt_d = 6'd0;
                end
            end
            START: begin
                if (last_s) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = '0;
                    cnt_d   = reload_s;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DATA: begin
                if (last_s) begin
                    cnt_d = reload_s;
                    if (bit_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                        bit_d   = bit_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            PARITY: begin
                if (last_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = reload_s;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            STOP: begin
                if (last_s) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= 6'd0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            presc_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            presc_q  <= presc_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, parity, timing,
// mid-frame disturbance, back-to-back acceptance and Prescale wrap.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  line_buf [0:1023];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Prescale   (prescale),
        .TX_OUT     (tx_out),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a one-cycle request; returns at the negedge right after the accepting edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Record the line at each negedge while Busy is high; n is the Busy length.
    task automatic capture(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            line_buf[n] = tx_out;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(8'h00, 1'b0, 1'b0, 6'd8);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre: tx=%b busy=%b, required tx=0 busy=1", tx_out, busy);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_idle[%0d]: tx=%b busy=%b, required tx=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_parity_even_a5;
        int n;
        logic [10:0] exp_bits;
        // start, A5 LSB first (1,0,1,0,0,1,0,1), even parity 0, stop; index 0 = start
        exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        capture(n);
        n_cmp++;
        if (n != 88) begin
            n_fail++; $display("FAIL a5_busy_len: got %0d, required 88", n);
        end
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (line_buf[k*8] !== exp_bits[k] || line_buf[k*8+7] !== exp_bits[k]) begin
                n_fail++; $display("FAIL a5_bit[%0d]: got %b/%b, required %b", k, line_buf[k*8], line_buf[k*8+7], exp_bits[k]);
            end
        end
    endtask

    task automatic test_no_parity_3c;
        int n;
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'h3C, 1'b0};
        send(8'h3C, 1'b0, 1'b0, 6'd16);
        capture(n);
        n_cmp++;
        if (n != 160) begin
            n_fail++; $display("FAIL 3c_busy_len: got %0d, required 160", n);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (line_buf[k*16] !== exp_bits[k] || line_buf[k*16+15] !== exp_bits[k]) begin
                n_fail++; $display("FAIL 3c_bit[%0d]: got %b/%b, required %b", k, line_buf[k*16], line_buf[k*16+15], exp_bits[k]);
            end
        end
    endtask

    task automatic test_parity_type;
        int n;
        send(8'h01, 1'b1, 1'b1, 6'd8);
        capture(n);
        n_cmp++;
        if (n != 88 || line_buf[9*8+4] !== 1'b0) begin
            n_fail++; $display("FAIL odd_parity_01: got bit %b len %0d, required bit 0 len 88", line_buf[9*8+4], n);
        end
        send(8'h01, 1'b1, 1'b0, 6'd8);
        capture(n);
        n_cmp++;
        if (n != 88 || line_buf[9*8+4] !== 1'b1) begin
            n_fail++; $display("FAIL even_parity_01: got bit %b len %0d, required bit 1 len 88", line_buf[9*8+4], n);
        end
    endtask

    task automatic test_mid_frame;
        int n;
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'h55, 1'b0};
        send(8'h55, 1'b0, 1'b0, 6'd8);
        fork
            capture(n);
            begin
                repeat (20) @(negedge clk);
                p_data = 8'hFF; prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
                @(negedge clk);
                data_valid = 1'b0;
            end
        join
        n_cmp++;
        if (n != 80) begin
            n_fail++; $display("FAIL mid_busy_len: got %0d, required 80", n);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (line_buf[k*8] !== exp_bits[k] || line_buf[k*8+7] !== exp_bits[k]) begin
                n_fail++; $display("FAIL mid_bit[%0d]: got %b/%b, required %b", k, line_buf[k*8], line_buf[k*8+7], exp_bits[k]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_no_queue[%0d]: tx=%b busy=%b, required tx=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        int t_idle, t_start, t;
        @(negedge clk);
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8; data_valid = 1'b1;
        @(negedge clk);
        t = 0; t_idle = -1; t_start = -1;
        while (t < 300 && t_start < 0) begin
            if (t_idle < 0 && busy === 1'b0) t_idle = t;
            if (t_idle >= 0 && busy === 1'b1 && tx_out === 1'b0) t_start = t;
            if (t_start < 0) begin
                @(negedge clk);
                t++;
            end
        end
        data_valid = 1'b0;
        n_cmp++;
        if (t_idle != 80) begin
            n_fail++; $display("FAIL b2b_idle_at: got %0d, required 80", t_idle);
        end
        n_cmp++;
        if (t_start != 81) begin
            n_fail++; $display("FAIL b2b_second_start: got %0d, required 81", t_start);
        end
        t = 0;
        while (busy === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_prescale_wrap;
        int n;
        send(8'h01, 1'b0, 1'b0, 6'd0);
        capture(n);
        n_cmp++;
        if (n != 640) begin
            n_fail++; $display("FAIL wrap_busy_len: got %0d, required 640", n);
        end
        n_cmp++;
        if (line_buf[63] !== 1'b0 || line_buf[64] !== 1'b1 || line_buf[127] !== 1'b1 || line_buf[128] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_edges: got %b%b%b%b, required 0110",
                               line_buf[63], line_buf[64], line_buf[127], line_buf[128]);
        end
    endtask

    initial begin
        test_reset();
        test_parity_even_a5();
        test_no_parity_3c();
        test_parity_type();
        test_mid_frame();
        test_back_to_back();
        test_prescale_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
